// File: rtl/ifetch_seq.sv
// Sequential byte-wide instruction fetch for the Y86-64 SEQ core: reads one
// byte per cycle, decodes length from icode, and presents the assembled fields.
module ifetch_seq #(
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [63:0] pc,
  output logic        busy,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        valid,
  output logic [7:0]  Byte0,
  output logic [71:0] Byte19,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [63:0] DEPTH64 = 64'(IMEM_DEPTH);

  logic [1:0]  state;
  logic [63:0] base;
  logic [3:0]  iss_idx;
  logic        ret_valid;
  logic [3:0]  ret_idx;
  logic [3:0]  len;
  logic        len_known;
  logic        stop;
  logic        spec_oor;

  logic        cap0;
  logic [3:0]  dec_len;
  logic [3:0]  n_eff;
  logic        known;
  logic [3:0]  next_idx;
  logic [64:0] next_sum;
  logic        next_oor;
  logic        want;
  logic        issue;
  logic        last;
  logic        done_now;
  logic        base_oor;

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] n;
    case (icode)
      4'h0, 4'h1, 4'h9:       n = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: n = 4'd2;
      4'h7, 4'h8:             n = 4'd9;
      4'h3, 4'h4, 4'h5:       n = 4'd10;
      default:                n = 4'd1;
    endcase
    return n;
  endfunction

  // Index 1 is decided before byte 0 returns, so N may still be unknown here;
  // an out-of-range speculative read is parked in spec_oor until N resolves.
  always_comb begin
    cap0     = ret_valid && (ret_idx == 4'd0);
    dec_len  = instr_len(mem_rdata[7:4]);
    n_eff    = cap0 ? dec_len : len;
    known    = len_known || cap0;
    next_idx = iss_idx + 4'd1;
    next_sum = {1'b0, base} + 65'(next_idx);
    next_oor = next_sum[64] || (next_sum[63:0] >= DEPTH64);
    want     = !stop && (!known || (next_idx < n_eff));
    issue    = want && !next_oor;
    last     = ret_valid && known && (ret_idx == (n_eff - 4'd1));
    done_now = last || (!mem_rd && !issue);
    base_oor = pc >= DEPTH64;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      iss_idx     <= '0;
      ret_valid   <= 1'b0;
      ret_idx     <= '0;
      len         <= '0;
      len_known   <= 1'b0;
      stop        <= 1'b0;
      spec_oor    <= 1'b0;
      busy        <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      valid       <= 1'b0;
      Byte0       <= '0;
      Byte19      <= '0;
      valP        <= '0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_rd    <= 1'b0;
          mem_addr  <= '0;
          ret_valid <= 1'b0;
          if (req) begin
            state       <= FETCH;
            busy        <= 1'b1;
            base        <= pc;
            iss_idx     <= '0;
            len         <= 4'd1;
            len_known   <= 1'b0;
            spec_oor    <= 1'b0;
            Byte0       <= '0;
            Byte19      <= '0;
            instr_valid <= 1'b0;
            if (base_oor) begin
              stop       <= 1'b1;
              imem_error <= 1'b1;
              valP       <= pc + 64'd1;
            end else begin
              stop       <= 1'b0;
              imem_error <= 1'b0;
              valP       <= '0;
              mem_rd     <= 1'b1;
              mem_addr   <= pc;
            end
          end
        end

        FETCH: begin
          ret_valid <= mem_rd;
          ret_idx   <= iss_idx;
          if (cap0) begin
            Byte0       <= mem_rdata;
            len         <= dec_len;
            len_known   <= 1'b1;
            instr_valid <= mem_rdata[7:4] <= 4'hB;
            valP        <= base + 64'(dec_len);
            if (spec_oor && (dec_len != 4'd1))
              imem_error <= 1'b1;
          end
          for (int unsigned k = 1; k <= 9; k++) begin
            if (ret_valid && (ret_idx == 4'(k)))
              Byte19[8*k-8 +: 8] <= mem_rdata;
          end
          if (want && next_oor) begin
            stop <= 1'b1;
            if (known)
              imem_error <= 1'b1;
            else
              spec_oor <= 1'b1;
          end
          mem_rd   <= issue;
          mem_addr <= issue ? next_sum[63:0] : '0;
          if (issue)
            iss_idx <= next_idx;
          if (done_now) begin
            state <= DONE;
            valid <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_rd    <= 1'b0;
          mem_addr  <= '0;
          ret_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: table of fetches with hand-computed results,
// plus reset-mid-fetch and ignored-request sequences.
module tb_ifetch_seq;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [63:0] pc;
  logic        busy;
  logic        mem_rd;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        valid;
  logic [7:0]  Byte0;
  logic [71:0] Byte19;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;

  ifetch_seq #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .pc(pc), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .valid(valid), .Byte0(Byte0), .Byte19(Byte19), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  int bad_rd = 0;

  always @(posedge clk) begin
    if (mem_rd) begin
      if (mem_addr < 64'(DEPTH)) mem_rdata <= mem[mem_addr[5:0]];
      else begin mem_rdata <= 8'hEE; bad_rd++; end
    end else begin
      mem_rdata <= 8'h5A;
    end
  end

  typedef struct {
    string       name;
    logic [63:0] pc;
    int          lat;
    logic [7:0]  b0;
    logic [71:0] b19;
    logic [63:0] valp;
    logic        iv;
    logic        err;
    int          rds;
  } vec_t;

  vec_t vecs[9];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issues one fetch; lat is the cycle (after the accept edge) in which valid is seen, 0 on timeout.
  task automatic run_fetch(input logic [63:0] a, output int lat, output int rds);
    @(negedge clk);
    req = 1'b1;
    pc  = a;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    rds = 0;
    for (int k = 1; k <= 30; k++) begin
      if (mem_rd) rds++;
      if (valid) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int lat, rds;
    run_fetch(v.pc, lat, rds);
    check({v.name, ".latency"},     72'(lat), 72'(v.lat));
    check({v.name, ".Byte0"},       72'(Byte0), 72'(v.b0));
    check({v.name, ".Byte19"},      Byte19, v.b19);
    check({v.name, ".valP"},        72'(valP), 72'(v.valp));
    check({v.name, ".instr_valid"}, 72'(instr_valid), 72'(v.iv));
    check({v.name, ".imem_error"},  72'(imem_error), 72'(v.err));
    check({v.name, ".mem_rd_cycles"}, 72'(rds), 72'(v.rds));
    @(negedge clk);
    check({v.name, ".valid_pulse"}, 72'({valid, busy}), 72'(0));
    check({v.name, ".hold_valP"},   72'(valP), 72'(v.valp));
  endtask

  initial begin
    int seen_valid, seen_rd;
    reset = 1'b1;
    req   = 1'b0;
    pc    = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'h00;
    mem[0]  = 8'h10;
    mem[5]  = 8'hE0;
    mem[8]  = 8'h60; mem[9] = 8'h23;
    mem[16] = 8'h70;
    for (int i = 1; i <= 8; i++) mem[16+i] = 8'hA0 + 8'(i);
    mem[32] = 8'h30; mem[33] = 8'hF3;
    for (int i = 1; i <= 8; i++) mem[33+i] = 8'(i);
    mem[60] = 8'h70; mem[61] = 8'h11; mem[62] = 8'h22; mem[63] = 8'h00;

    vecs[0] = '{"nop",      64'd0,  3,  8'h10, 72'h0, 64'd1,  1'b1, 1'b0, 2};
    vecs[1] = '{"irmovq",   64'h20, 12, 8'h30, 72'h0807060504030201F3, 64'h2A, 1'b1, 1'b0, 10};
    vecs[2] = '{"invalid",  64'd5,  3,  8'hE0, 72'h0, 64'd6,  1'b0, 1'b0, 2};
    vecs[3] = '{"opq",      64'd8,  4,  8'h60, 72'h23, 64'h0A, 1'b1, 1'b0, 2};
    vecs[4] = '{"jxx",      64'h10, 11, 8'h70, 72'hA8A7A6A5A4A3A2A1, 64'h19, 1'b1, 1'b0, 9};
    vecs[5] = '{"oor_tail", 64'd60, 6,  8'h70, 72'h002211, 64'd69, 1'b1, 1'b1, 4};
    vecs[6] = '{"oor_base", 64'd64, 2,  8'h00, 72'h0, 64'd65, 1'b0, 1'b1, 0};
    vecs[7] = '{"halt_last", 64'd63, 3, 8'h00, 72'h0, 64'd64, 1'b1, 1'b0, 1};
    vecs[8] = '{"oor_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 2, 8'h00, 72'h0, 64'd0, 1'b0, 1'b1, 0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset.outputs", 72'({busy, mem_rd, valid, instr_valid, imem_error}), 72'(0));
    check("reset.valP", 72'(valP), 72'(0));

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Reset during a 10-byte fetch, in cycle t+5.
    @(negedge clk);
    req = 1'b1; pc = 64'h20;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset.flags", 72'({busy, mem_rd, valid, instr_valid, imem_error}), 72'(0));
    check("midreset.mem_addr", 72'(mem_addr), 72'(0));
    check("midreset.Byte0", 72'(Byte0), 72'(0));
    check("midreset.Byte19", Byte19, 72'(0));
    check("midreset.valP", 72'(valP), 72'(0));
    seen_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid || busy) seen_valid++;
    end
    check("midreset.no_activity", 72'(seen_valid), 72'(0));
    apply_vec(vecs[0]);

    // req held through FETCH and DONE must not start a second fetch.
    @(negedge clk);
    req = 1'b1; pc = 64'd8;
    @(negedge clk);
    pc = 64'h20;
    seen_valid = 0;
    seen_rd = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) req = 1'b0;
      if (valid) seen_valid++;
      if (mem_rd) seen_rd++;
      @(negedge clk);
    end
    check("ignored_req.valid_count", 72'(seen_valid), 72'(1));
    check("ignored_req.mem_rd_cycles", 72'(seen_rd), 72'(2));
    check("ignored_req.Byte0", 72'(Byte0), 72'(8'h60));
    check("ignored_req.valP", 72'(valP), 72'(64'h0A));
    check("no_oor_reads", 72'(bad_rd), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
